fetch_icache: RTL and testbench
===============================

// Module: fetch_icache
// PURPOSE
//  Instruction-side responder for the fetch address generator: takes instruction_address,
//  returns instruction and the hit flag that gates the PC+4 adder (hit=0 stalls fetch).
//  Direct-mapped, read-only I-cache; on a miss it runs a line refill from backing memory
//  over a req/ack word handshake, then services the held PC on the following cycle.
// PARAMETERS
//  LINES           16   number of cache lines (power of 2, >=2)
//  WORDS_PER_LINE  4    32-bit words per line (power of 2, >=2)
// PORTS
//  clk                  in   1   rising-edge clock
//  rst_n                in   1   asynchronous active-low reset
//  instruction_address  in   32  fetch PC from fetch_address_generator; bits [1:0] ignored
//  flush                in   1   invalidate all lines (e.g. after self-modifying store)
//  hit                  out  1   instruction valid this cycle; drives fetch_add hit
//  instruction          out  32  fetched word; 32'h0000_0000 (NOP) when hit=0
//  mem_req              out  1   refill word request to backing memory
//  mem_addr             out  32  word-aligned refill address, stable while mem_req=1
//  mem_ack              in   1   memory returns mem_data this cycle for current mem_addr
//  mem_data             in   32  refill word
// BEHAVIOUR
//  - Address split: OFF=log2(WORDS_PER_LINE), IDX=log2(LINES), TAG=30-IDX-OFF;
//    word=addr[OFF+1:2], index=addr[OFF+IDX+1:OFF+2], tag=addr[31:OFF+IDX+2].
//  - Reset: all valid bits 0, state IDLE, hit=0, instruction=0, mem_req=0, mem_addr=0,
//    word counter 0. Data/tag arrays not reset. Reset mid-refill aborts it; line stays invalid.
//  - Lookup is combinational: hit = (state==IDLE) & valid[index] & (tag_arr[index]==tag).
//    instruction = hit ? data[index][word] : 0. Zero-cycle latency on hit.
//  - FSM states: IDLE, REFILL.
//    IDLE: hit -> stay. Miss (and not flush) -> latch miss tag/index, clear valid[index],
//      counter=0, mem_req=1, mem_addr={tag,index,OFF'b0,2'b00}; go REFILL next edge.
//    REFILL: mem_req held 1, mem_addr stable until mem_ack sampled 1. On each ack write
//      mem_data to data[index][counter], counter++, mem_addr advances +4 next cycle.
//      Ack on last word (counter==WORDS_PER_LINE-1): write tag, set valid[index]
//      (unless flush_pending), mem_req=0, go IDLE. Held PC then hits the cycle after.
//  - Refill always fetches whole line from word 0; arbitrary mem_ack gaps allowed; one word
//    per ack, acks while mem_req=0 ignored.
//  - instruction_address changes during REFILL (branch PCSrc): refill completes on latched
//    address; new address looked up in IDLE afterwards (may miss again).
//  - flush in IDLE: all valid bits cleared next edge; hit forced 0 that cycle.
//    flush in REFILL: valid bits cleared, flush_pending set; refill runs to completion but
//    line is not marked valid; flush_pending cleared on return to IDLE.
//  - Miss on the same index as a valid line evicts it (tag overwritten).
//  - mem_addr upper bits never wrap beyond the line: counter saturates at last word.
// STRUCTURE
//  - mips_pkg: icache_state_t enum {IDLE, REFILL}; WORD_BYTES=4; NOP_INSTR=32'h0.
//    Width localparams (OFF/IDX/TAG) derived locally from parameters.
//  - One sub-module: icache_refill_fsm (state, counter, mem_req/mem_addr, flush_pending);
//    tag/valid/data arrays and lookup remain in fetch_icache.
// TESTING
//  1 Cold miss: rst_n low then high, PC=0x0000_0040 -> hit=0, mem_req=1 mem_addr=0x40,
//    acks return 0xA0..0xA3 at 0x40..0x4C; cycle after last ack hit=1 instruction=0xA0.
//  2 Hit sweep: after test 1, PC=0x44,0x48,0x4C -> hit=1 each cycle, 0xA1,0xA2,0xA3, mem_req=0.
//  3 Conflict: PC=0x0000_0440 (same index, new tag) -> miss, refill from 0x440; then
//    PC=0x40 -> miss again (evicted).
//  4 Flush mid-refill: assert flush after 2nd ack -> refill finishes 4 words, hit stays 0,
//    new refill of same line starts next cycle.
//  5 Ack stalls + branch: mem_ack gaps of 0..5 cycles, PC changed mid-refill to 0x100 ->
//    mem_addr stable across gaps, original line completes, then refill at 0x100.
//  6 Reset mid-refill: rst_n low after 1 ack -> mem_req=0 immediately, hit=0; re-fetch misses.

Source files
------------

// File: rtl/fetch_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_icache_pkg
//  Purpose  : Shared types and constants for the fetch-side instruction cache.
//             Provides the refill FSM state type, the word size and the NOP
//             returned on a miss.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fetch_icache_pkg;

    // Refill controller states: IDLE serves lookups, REFILL streams a line in.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_t;

    localparam int          WORD_BYTES = 4;
    localparam int          BYTE_OFF   = $clog2(WORD_BYTES);
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage : fetch_icache_pkg
`default_nettype wire

// File: rtl/fetch_icache_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_icache_if
//  Purpose  : Refill bus between the instruction cache and backing memory.
//             One word moves per cycle in which mem_ack is high while
//             mem_req is high.
//  Signals  : mem_req  - refill word request (cache -> memory)
//             mem_addr - word-aligned refill address (cache -> memory)
//             mem_ack  - mem_data valid for current mem_addr (memory -> cache)
//             mem_data - refill word (memory -> cache)
//  Modports : master (cache side), slave (memory side)
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_icache_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );

endinterface : fetch_icache_if
`default_nettype wire

// File: rtl/fetch_icache_refill_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_fsm
//  Purpose  : Line refill controller for the direct-mapped instruction cache.
//             Latches the missing line address, issues one word request per
//             ack from word 0 to the last word, and tracks flushes that land
//             while a refill is in flight so the line is not validated.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             start             - miss detected in IDLE, begin a refill
//             miss_line         - {tag,index} of the missing line
//             flush             - invalidate-all request
//             mem_ack           - memory word return strobe
//             state             - current controller state
//             counter           - word being filled
//             fill_line         - {tag,index} of the line being filled
//             mem_req/mem_addr  - registered refill request and address
//             fill_we           - write mem_data into the line this cycle
//             fill_done         - last word of the line arrives this cycle
//             fill_set_valid    - mark the filled line valid this cycle
//  Revision : 1.0  initial release
// ============================================================================
module icache_refill_fsm
    import fetch_icache_pkg::*;
#(
    parameter int OFF_W  = 2,
    parameter int LINE_W = 28
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [LINE_W-1:0]  miss_line,
    input  wire logic               flush,
    input  wire logic               mem_ack,
    output icache_state_t           state,
    output logic [OFF_W-1:0]        counter,
    output logic [LINE_W-1:0]       fill_line,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    output logic                    fill_we,
    output logic                    fill_done,
    output logic                    fill_set_valid
);

    localparam logic [OFF_W-1:0] c_last_word = {OFF_W{1'b1}};
    localparam logic [OFF_W-1:0] c_one       = {{(OFF_W-1){1'b0}}, 1'b1};

    icache_state_t      r_state;
    logic [OFF_W-1:0]   r_counter;
    logic [LINE_W-1:0]  r_line;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic               r_flush_pending;

    logic               w_last;
    logic [OFF_W-1:0]   w_counter_next;

    assign w_last         = (r_counter == c_last_word);
    assign w_counter_next = r_counter + c_one;

    // Acks are only meaningful while a request is outstanding.
    assign fill_we        = (r_state == REFILL) && mem_ack;
    assign fill_done      = fill_we && w_last;
    // A flush arriving on the final ack wins over validating the line.
    assign fill_set_valid = fill_done && !r_flush_pending && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_counter       <= '0;
            r_line          <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_flush_pending <= 1'b0;
                    if (start) begin
                        r_line     <= miss_line;
                        r_counter  <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {miss_line, {OFF_W{1'b0}}, {BYTE_OFF{1'b0}}};
                        r_state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (mem_ack) begin
                        if (w_last) begin
                            // Counter saturates on the last word; the address
                            // therefore never walks past the end of the line.
                            r_mem_req <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_counter  <= w_counter_next;
                            r_mem_addr <= {r_line, w_counter_next, {BYTE_OFF{1'b0}}};
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign counter   = r_counter;
    assign fill_line = r_line;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;

endmodule : icache_refill_fsm
`default_nettype wire

// File: rtl/fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_icache
//  Purpose  : Direct-mapped, read-only instruction cache for the fetch stage.
//             Lookup is combinational (zero-cycle hit). A miss stalls fetch
//             (hit=0) while the whole line is refilled from backing memory;
//             the held PC hits on the cycle after the last refill word.
//  Ports    : clk                 - rising-edge clock
//             rst_n               - asynchronous active-low reset
//             instruction_address - fetch PC, bits [1:0] ignored
//             flush               - invalidate every line
//             hit                 - instruction valid this cycle
//             instruction         - fetched word, NOP when hit=0
//             mem                 - refill bus (master side)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_icache
    import fetch_icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [31:0]  instruction_address,
    input  wire logic         flush,
    output logic              hit,
    output logic [31:0]       instruction,
    fetch_icache_if.master    mem
);

    localparam int OFF    = $clog2(WORDS_PER_LINE);
    localparam int IDX    = $clog2(LINES);
    localparam int TAG    = 30 - IDX - OFF;
    localparam int LINE_W = TAG + IDX;
    localparam int DEPTH  = LINES * WORDS_PER_LINE;

    // Address decomposition of the current PC.
    logic [OFF-1:0]     w_word;
    logic [IDX-1:0]     w_index;
    logic [TAG-1:0]     w_tag;
    logic [LINE_W-1:0]  w_line;
    logic               w_unused_byte_bits;

    assign w_word             = instruction_address[OFF+1:2];
    assign w_index            = instruction_address[OFF+IDX+1:OFF+2];
    assign w_tag              = instruction_address[31:OFF+IDX+2];
    assign w_line             = instruction_address[31:OFF+2];
    assign w_unused_byte_bits = &{1'b0, instruction_address[1:0]};

    // Storage: valid bits are reset, tag and data arrays are not.
    logic [LINES-1:0]   r_valid;
    logic [TAG-1:0]     r_tag [LINES];
    logic [31:0]        r_data [DEPTH];

    // Refill controller interface.
    icache_state_t      w_state;
    logic [OFF-1:0]     w_counter;
    logic [LINE_W-1:0]  w_fill_line;
    logic [IDX-1:0]     w_fill_index;
    logic [TAG-1:0]     w_fill_tag;
    logic               w_fill_we;
    logic               w_fill_done;
    logic               w_fill_set_valid;

    assign w_fill_index = w_fill_line[IDX-1:0];
    assign w_fill_tag   = w_fill_line[LINE_W-1:IDX];

    // Lookup. Flush forces a miss in the same cycle and suppresses a new
    // refill, since every line is about to be invalidated anyway.
    logic               w_match;
    logic               w_idle;
    logic               w_start;

    assign w_idle  = (w_state == IDLE);
    assign w_match = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign hit     = w_idle && w_match && !flush;
    assign w_start = w_idle && !w_match && !flush;

    assign instruction = hit ? r_data[{w_index, w_word}] : NOP_INSTR;

    icache_refill_fsm #(
        .OFF_W  (OFF),
        .LINE_W (LINE_W)
    ) u_refill_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (w_start),
        .miss_line      (w_line),
        .flush          (flush),
        .mem_ack        (mem.mem_ack),
        .state          (w_state),
        .counter        (w_counter),
        .fill_line      (w_fill_line),
        .mem_req        (mem.mem_req),
        .mem_addr       (mem.mem_addr),
        .fill_we        (w_fill_we),
        .fill_done      (w_fill_done),
        .fill_set_valid (w_fill_set_valid)
    );

    // Valid bits: the missing line is invalidated when its refill starts so
    // an aborted refill (reset) never leaves a half-written line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_start) begin
                r_valid[w_index] <= 1'b0;
            end
            if (w_fill_set_valid) begin
                r_valid[w_fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: written only by the refill engine.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_fill_index, w_counter}] <= mem.mem_data;
        end
        if (w_fill_done) begin
            r_tag[w_fill_index] <= w_fill_tag;
        end
    end

endmodule : fetch_icache
`default_nettype wire

// File: tb/tb_fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_icache
//  Purpose  : Directed self-checking bench for fetch_icache with a backing
//             memory model and an expected-instruction scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_icache;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction_address;
    logic        flush;
    logic        hit;
    logic [31:0] instruction;

    fetch_icache_if mem_if ();

    fetch_icache #(
        .LINES          (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .flush               (flush),
        .hit                 (hit),
        .instruction         (instruction),
        .mem                 (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] exp_q[$];

    // Backing memory contents: 0x40 -> 0xA0, 0x44 -> 0xA1, ... linear in address.
    function automatic logic [31:0] backing(input logic [31:0] a);
        return 32'h0000_00A0 + ((a - 32'h0000_0040) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check a hit cycle against the head of the scoreboard.
    task automatic chk_hit(input string tag);
        logic [31:0] e;
        chk({tag, "_hit"}, {31'b0, hit}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, instruction, e);
        end
    endtask

    task automatic chk_miss(input string tag);
        chk({tag, "_hit"}, {31'b0, hit}, 32'd0);
        chk({tag, "_nop"}, instruction, 32'h0);
    endtask

    // Drive a new PC at a negedge and record the instruction it must return.
    task automatic fetch_pc(input logic [31:0] pc);
        @(negedge clk);
        instruction_address = pc;
        exp_q.push_back(backing(pc));
        #1;
    endtask

    // Serve a refill of the line at base. Entered in the IDLE miss cycle.
    // gaps[4w+:4] idle cycles precede word w; flush_at/br_at pick the word
    // whose ack cycle also raises flush / redirects the PC (-1 = never).
    task automatic refill(input logic [31:0] base, input logic [15:0] gaps,
                          input int flush_at, input int br_at, input logic [31:0] br_pc);
        logic [31:0] a;
        for (int w = 0; w < 4; w++) begin
            a = base + 32'(4 * w);
            for (int g = 0; g < int'(gaps[4*w +: 4]); g++) begin
                @(negedge clk);
                mem_if.mem_ack = 1'b0;
                flush          = 1'b0;
                #1;
                chk("gap_req",  {31'b0, mem_if.mem_req}, 32'd1);
                chk("gap_addr", mem_if.mem_addr, a);
                chk("gap_hit",  {31'b0, hit}, 32'd0);
            end
            @(negedge clk);
            if (w == br_at) begin
                instruction_address = br_pc;
                exp_q.delete();
                exp_q.push_back(backing(br_pc));
            end
            flush           = (w == flush_at);
            mem_if.mem_ack  = 1'b1;
            mem_if.mem_data = backing(a);
            #1;
            chk("ack_req",  {31'b0, mem_if.mem_req}, 32'd1);
            chk("ack_addr", mem_if.mem_addr, a);
            chk("ack_hit",  {31'b0, hit}, 32'd0);
        end
        @(negedge clk);
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_data = 32'hDEAD_BEEF;
        flush           = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n               = 1'b0;
        flush               = 1'b0;
        instruction_address = 32'h0000_0040;
        mem_if.mem_ack      = 1'b0;
        mem_if.mem_data     = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hit",   {31'b0, hit}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_req",   {31'b0, mem_if.mem_req}, 32'd0);
        chk("rst_addr",  mem_if.mem_addr, 32'h0);

        // 1: cold miss at 0x40, refill 0xA0..0xA3, hit with 0xA0.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(backing(32'h40));
        #1;
        chk_miss("cold");
        chk("cold_req0", {31'b0, mem_if.mem_req}, 32'd0);
        refill(32'h40, 16'h0000, -1, -1, 32'h0);
        chk_hit("cold_done");
        chk("cold_req_off", {31'b0, mem_if.mem_req}, 32'd0);

        // 2: hit sweep through the rest of the line.
        for (int i = 1; i < 4; i++) begin
            fetch_pc(32'h40 + 32'(4 * i));
            chk_hit("sweep");
            chk("sweep_req", {31'b0, mem_if.mem_req}, 32'd0);
        end

        // 3: conflict on index 4, then the evicted line misses again.
        fetch_pc(32'h440);
        chk_miss("conf");
        refill(32'h440, 16'h0000, -1, -1, 32'h0);
        chk_hit("conf_done");
        fetch_pc(32'h40);
        chk_miss("evict");
        refill(32'h40, 16'h0000, -1, -1, 32'h0);
        chk_hit("evict_done");

        // 4: flush after the 2nd ack; line not validated, refetch restarts.
        fetch_pc(32'h440);
        chk_miss("fl");
        refill(32'h440, 16'h0000, 2, -1, 32'h0);
        chk_miss("fl_after");
        refill(32'h440, 16'h0000, -1, -1, 32'h0);
        chk_hit("fl_refetch");

        // 5: ack gaps 0/3/5/1 with a branch to 0x100 during the refill of 0x80.
        fetch_pc(32'h80);
        chk_miss("br");
        refill(32'h80, 16'h1530, -1, 1, 32'h100);
        chk_miss("br_after");
        refill(32'h100, 16'h0102, -1, -1, 32'h0);
        chk_hit("br_target");
        fetch_pc(32'h80);
        chk_hit("br_orig_line");

        // 6: reset after one ack aborts the refill; refetch misses.
        fetch_pc(32'h200);
        chk_miss("rm");
        @(negedge clk);
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_data = backing(32'h200);
        #1;
        chk("rm_req", {31'b0, mem_if.mem_req}, 32'd1);
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        rst_n          = 1'b0;
        #1;
        chk("rm_req_off", {31'b0, mem_if.mem_req}, 32'd0);
        chk("rm_addr",    mem_if.mem_addr, 32'h0);
        chk_miss("rm_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_miss("rm_refetch");
        refill(32'h200, 16'h0000, -1, -1, 32'h0);
        chk_hit("rm_done");

        // Flush in IDLE: hit forced low, then the line is gone.
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk_miss("idle_flush");
        chk("idle_flush_req", {31'b0, mem_if.mem_req}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        exp_q.push_back(backing(32'h200));
        #1;
        chk_miss("post_flush");
        refill(32'h200, 16'h0000, -1, -1, 32'h0);
        chk_hit("post_flush_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_icache
`default_nettype wire
